// File: rtl/diff_digota_drv_if.sv
// diff_digota_drv_if: drive-request, enable and readback bundle between the stimulus controller and its user.
interface diff_digota_drv_if #(parameter int W = 8);
  logic en;
  logic signed [W-1:0] code;
  logic OUTp;
  logic OUTm;
  logic INpb;
  logic INmb;
  logic oe;
  logic fault;
  logic tick;
  modport master (output en, code, OUTp, OUTm, input INpb, INmb, oe, fault, tick);
  modport slave (input en, code, OUTp, OUTm, output INpb, INmb, oe, fault, tick);
endinterface

// File: rtl/diff_digota_drv.sv
// diff_digota_drv: first-order sigma-delta driver for a differential digital OTA stage,
// with break-before-make dead time and readback-based stuck-stage detection.
module diff_digota_drv #(
  parameter int W    = 8,
  parameter int DIV  = 4,
  parameter int DEAD = 2,
  parameter int TO   = 15
) (
  input logic clk,
  input logic rst,
  diff_digota_drv_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRV_P = 2'd1;
  localparam logic [1:0] ST_DRV_N = 2'd2;
  localparam logic [1:0] ST_DEAD  = 2'd3;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = DEAD > 0 ? $clog2(DEAD + 1) : 1;
  localparam int MW = $clog2(TO + 1);
  localparam logic signed [W+1:0] HALF = {3'b001, {(W-1){1'b0}}};
  logic [DW-1:0] div_q, div_d;
  logic signed [W+1:0] acc_q, acc_d;
  logic [1:0] state_q, state_d;
  logic pend_q, pend_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [MW-1:0] mis_q, mis_d;
  logic [1:0] sp_q, sp_d, sm_q, sm_d;
  logic fault_q, fault_d, tick_q, tick_d;
  logic inpb_q, inpb_d, inmb_q, inmb_d, oe_q, oe_d;
  logic wrap, y_p, drv, exp_ok, mis_hit, fault_set, hold, tk;
  logic signed [W+1:0] code_x;
  always_comb begin
    wrap      = div_q == DW'(DIV - 1);
    y_p       = ~acc_q[W+1];
    code_x    = {{2{bus.code[W-1]}}, bus.code};
    drv       = state_q == ST_DRV_P || state_q == ST_DRV_N;
    exp_ok    = state_q == ST_DRV_P ? (sp_q[1] & ~sm_q[1]) : (~sp_q[1] & sm_q[1]);
    mis_hit   = drv & ~exp_ok;
    fault_set = mis_hit && mis_q == MW'(TO - 1);
    hold      = fault_q | fault_set;
    tk        = bus.en & ~hold & wrap;
    div_d     = bus.en ? (wrap ? '0 : div_q + 1'b1) : '0;
    acc_d     = !bus.en ? '0 : tk ? acc_q + code_x + (y_p ? -HALF : HALF) : acc_q;
    state_d   = state_q;
    pend_d    = pend_q;
    dcnt_d    = '0;
    if (!bus.en || hold) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = tk ? (y_p ? ST_DRV_P : ST_DRV_N) : ST_IDLE;
        ST_DRV_P: if (tk && !y_p) begin
                    state_d = ST_DEAD;
                    pend_d  = 1'b0;
                  end
        ST_DRV_N: if (tk && y_p) begin
                    state_d = ST_DEAD;
                    pend_d  = 1'b1;
                  end
        default:  if (dcnt_q == CW'(DEAD - 1)) state_d = pend_q ? ST_DRV_P : ST_DRV_N;
                  else dcnt_d = dcnt_q + 1'b1;
      endcase
    end
    // a polarity change, idle or dead time restarts the stuck-stage count
    mis_d   = (mis_hit && state_d == state_q) ? mis_q + 1'b1 : '0;
    fault_d = bus.en & hold;
    tick_d  = tk;
    inpb_d  = state_d != ST_DRV_P;
    inmb_d  = state_d != ST_DRV_N;
    oe_d    = state_d != ST_IDLE;
    sp_d    = {sp_q[0], bus.OUTp};
    sm_d    = {sm_q[0], bus.OUTm};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      acc_q   <= '0;
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      dcnt_q  <= '0;
      mis_q   <= '0;
      sp_q    <= '0;
      sm_q    <= '0;
      fault_q <= 1'b0;
      tick_q  <= 1'b0;
      inpb_q  <= 1'b1;
      inmb_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      dcnt_q  <= dcnt_d;
      mis_q   <= mis_d;
      sp_q    <= sp_d;
      sm_q    <= sm_d;
      fault_q <= fault_d;
      tick_q  <= tick_d;
      inpb_q  <= inpb_d;
      inmb_q  <= inmb_d;
      oe_q    <= oe_d;
    end
  end
  assign bus.INpb  = inpb_q;
  assign bus.INmb  = inmb_q;
  assign bus.oe    = oe_q;
  assign bus.fault = fault_q;
  assign bus.tick  = tick_q;
endmodule
